// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter among NREQ byte requesters
// Optional feature macro: UART_ARB_TIMEOUT_EN (abort a transfer whose tx_done never arrives)
module uart_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int DW      = 8,
    parameter int TIMEOUT = 4000
) (
    input  logic               clk2,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    ack,
    output logic [IDW-1:0]     cur_id,
    output logic               arb_busy,
    output logic               tx_start,
    output logic [DW-1:0]      tx_data,
    input  logic               tx_busy,
    input  logic               tx_done,
    output logic               timeout_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]     state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] sel;
    logic           found;
    logic [IDW:0]   cand;
    logic [IDW-1:0] next_ptr;
    logic           done_ok;
    logic           to_hit;
    logic [DW-1:0]  data_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign data_arr[i] = req_data[i*DW +: DW];
    end

    // Pick the first pending requester starting at ptr, wrapping modulo NREQ
    always_comb begin
        sel   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (!found && req[cand[IDW-1:0]]) begin
                found = 1'b1;
                sel   = cand[IDW-1:0];
            end
        end
    end

    assign next_ptr = (cur_id == IDW'(NREQ-1)) ? '0 : cur_id + IDW'(1);

    // A done pulse coinciding with our own start pulse belongs to no transfer of ours
    assign done_ok = tx_done && !tx_start;

`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0] to_cnt;

    assign to_hit = (to_cnt == 16'(TIMEOUT-1));

    // Watchdog counter: cleared while leaving START, counts every WAIT_DONE cycle
    always_ff @(posedge clk2) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (state == S_START) begin
            to_cnt <= '0;
        end else if (state == S_WAIT) begin
            to_cnt <= to_cnt + 16'd1;
        end
    end

    // Abort pulse when the watchdog expires and no done arrives in that same cycle
    always_ff @(posedge clk2) begin
        if (rst) begin
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= (state == S_WAIT) && !done_ok && to_hit;
        end
    end
`else
    assign to_hit      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Arbitration FSM: grant/capture, start the transmitter, wait for completion
    always_ff @(posedge clk2) begin
        if (rst) begin
            state    <= S_IDLE;
            ptr      <= '0;
            gnt      <= '0;
            ack      <= '0;
            cur_id   <= '0;
            arb_busy <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else begin
            tx_start <= 1'b0;
            ack      <= '0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        gnt      <= NREQ'(1) << sel;
                        cur_id   <= sel;
                        tx_data  <= data_arr[sel];
                        arb_busy <= 1'b1;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (done_ok) begin
                        ack      <= gnt;
                        gnt      <= '0;
                        ptr      <= next_ptr;
                        arb_busy <= 1'b0;
                        state    <= S_IDLE;
                    end else if (to_hit) begin
                        gnt      <= '0;
                        ptr      <= next_ptr;
                        arb_busy <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: begin
                    gnt      <= '0;
                    arb_busy <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    logic        clk2 = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [1:0]  cur_id;
    logic        arb_busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        tx_done;
    logic        timeout_err;

    int pass_cnt = 0;
    int total    = 0;

    uart_tx_arbiter #(.NREQ(4), .IDW(2), .DW(8), .TIMEOUT(16)) dut (
        .clk2(clk2), .rst(rst), .req(req), .req_data(req_data),
        .gnt(gnt), .ack(ack), .cur_id(cur_id), .arb_busy(arb_busy),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .tx_done(tx_done), .timeout_err(timeout_err)
    );

    always #5 clk2 = ~clk2;

    task automatic tick();
        @(posedge clk2);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1; req = '0; req_data = '0; tx_busy = 1'b0; tx_done = 1'b0;
        tick(); tick();
        check("rst_gnt", 32'(gnt), 0);
        check("rst_ack", 32'(ack), 0);
        check("rst_cur_id", 32'(cur_id), 0);
        check("rst_busy", 32'(arb_busy), 0);
        check("rst_tx_start", 32'(tx_start), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_timeout_err", 32'(timeout_err), 0);
        rst = 1'b0;

        // single request on requester 1
        req = 4'b0010; req_data = 32'h44_33_A5_11;
        tick();
        check("single_gnt", 32'(gnt), 32'h2);
        check("single_tx_data", 32'(tx_data), 32'hA5);
        check("single_cur_id", 32'(cur_id), 1);
        check("single_busy", 32'(arb_busy), 1);
        check("single_no_start_yet", 32'(tx_start), 0);
        req_data = 32'h44_33_5A_11; req = '0;
        tick();
        check("single_tx_start", 32'(tx_start), 1);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("same_cycle_done_ignored_ack", 32'(ack), 0);
        check("same_cycle_done_ignored_busy", 32'(arb_busy), 1);
        check("single_start_one_cycle", 32'(tx_start), 0);
        for (int i = 0; i < 18; i++) begin
            tick();
            check("single_wait_ack", 32'(ack), 0);
        end
        check("single_data_held", 32'(tx_data), 32'hA5);
        check("single_gnt_held", 32'(gnt), 32'h2);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("single_ack", 32'(ack), 32'h2);
        check("single_gnt_clear", 32'(gnt), 0);
        check("single_busy_low", 32'(arb_busy), 0);
        tick();
        check("single_ack_one_cycle", 32'(ack), 0);

        // reset in the middle of a transfer
        req = 4'b0100;
        tick(); tick(); tick();
        check("mid_in_wait", 32'(arb_busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0; req = '0;
        check("mid_rst_gnt", 32'(gnt), 0);
        check("mid_rst_busy", 32'(arb_busy), 0);
        check("mid_rst_tx_start", 32'(tx_start), 0);
        check("mid_rst_ack", 32'(ack), 0);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("stray_done_after_rst_ack", 32'(ack), 0);

        // rotation with all requesters held; first grant to 0 shows ptr was reset
        req = 4'b1111; req_data = 32'hD3_C2_B1_A0;
        for (int n = 0; n < 5; n++) begin
            automatic int id = n % 4;
            automatic logic [31:0] exp_data = 32'hA0 + 32'h11 * 32'(id);
            tick();
            check("rr_gnt", 32'(gnt), 32'(1) << id);
            check("rr_tx_data", 32'(tx_data), exp_data);
            check("rr_no_back_to_back_ack", 32'(ack), 0);
            tick();
            check("rr_tx_start", 32'(tx_start), 1);
            tick();
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
            check("rr_ack", 32'(ack), 32'(1) << id);
            if (n == 4) req = '0;
        end
        tick();
        check("rr_idle_gnt", 32'(gnt), 0);

        // busy hold-off; ptr is now 1 so lone requester 0 wins after wrap
        tx_busy = 1'b1; req = 4'b0001;
        tick();
        check("busy_gnt", 32'(gnt), 32'h1);
        req = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("busy_hold_no_start", 32'(tx_start), 0);
        end
        tx_busy = 1'b0;
        tick();
        check("busy_release_start", 32'(tx_start), 1);
        tick();
        check("busy_start_one_cycle", 32'(tx_start), 0);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("busy_ack", 32'(ack), 32'h1);

        // withdrawal after grant, then stray done in IDLE
        req = 4'b0100;
        tick();
        check("wd_gnt", 32'(gnt), 32'h4);
        req = '0;
        tick(); tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("wd_ack", 32'(ack), 32'h4);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("stray_idle_ack", 32'(ack), 0);
        check("stray_idle_busy", 32'(arb_busy), 0);
        check("stray_idle_gnt", 32'(gnt), 0);

        // ptr is now 3; requesters 0 and 1 pending, 0 wins first
        req = 4'b0011;
        tick();
        check("to_gnt", 32'(gnt), 32'h1);
        tick();
        check("to_tx_start", 32'(tx_start), 1);
`ifdef UART_ARB_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            tick();
            check("to_no_err_yet", 32'(timeout_err), 0);
        end
        tick();
        check("to_err_pulse", 32'(timeout_err), 1);
        check("to_no_ack", 32'(ack), 0);
        check("to_gnt_clear", 32'(gnt), 0);
        tick();
        check("to_err_one_cycle", 32'(timeout_err), 0);
        check("to_next_gnt", 32'(gnt), 32'h2);
`else
        for (int i = 0; i < 40; i++) begin
            tick();
            check("nto_still_waiting", 32'(arb_busy), 1);
            check("nto_err_zero", 32'(timeout_err), 0);
        end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("nto_ack", 32'(ack), 32'h1);
        tick();
        check("nto_next_gnt", 32'(gnt), 32'h2);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares one UART transmitter among NREQ byte requesters.
- Sits between the requesters (command/status sources) and the UART TX serialiser.
- Captures the granted byte and issues a one-cycle start pulse to the transmitter.
- Waits for the transmitter's done pulse, then acknowledges the requester and rotates priority.

Parameters:
- NREQ, 4, number of requesters (2..8)
- IDW, 2, width of requester index; must satisfy 2**IDW >= NREQ
- DW, 8, data byte width
- TIMEOUT, 4000, clk2 cycles allowed in WAIT_DONE before abort (only used with UART_ARB_TIMEOUT_EN)

Ports:
- clk2, in, 1, system clock; all logic on its rising edge
- rst, in, 1, synchronous active-high reset
- req, in, NREQ, per-requester request level
- req_data, in, NREQ*DW, packed bytes; requester i occupies bits [i*DW +: DW]
- gnt, out, NREQ, one-hot grant; held from capture until completion
- ack, out, NREQ, one-cycle completion pulse to the served requester
- cur_id, out, IDW, index of the granted requester; valid while arb_busy
- arb_busy, out, 1, high whenever state != IDLE
- tx_start, out, 1, one-cycle start pulse to the transmitter
- tx_data, out, DW, captured byte; stable from grant until completion
- tx_busy, in, 1, transmitter busy level
- tx_done, in, 1, transmitter completion pulse
- timeout_err, out, 1, one-cycle abort pulse; tied 0 without the macro

Behaviour:
- Reset: rst=1 at a clk2 edge forces the following:
  - state=IDLE, ptr=0
  - gnt=0, ack=0, cur_id=0, arb_busy=0, tx_start=0, tx_data=0, timeout_err=0
  - Applies in any state, including mid-transfer. No ack or tx_start is emitted for an aborted transfer.
- ptr (IDW bits) is the highest-priority index. The search order is ptr, ptr+1, …, wrapping modulo NREQ (not 2**IDW).
- IDLE:
  - If req != 0, select the first set bit in search order.
  - Register gnt=one-hot(sel), cur_id=sel, tx_data=req_data[sel], arb_busy=1.
  - Next state START.
  - If req == 0, stay in IDLE with outputs low.
- START:
  - If tx_busy=0, assert tx_start=1 for exactly one cycle and go to WAIT_DONE.
  - If tx_busy=1, hold in START with tx_start=0 and retry each cycle.
- WAIT_DONE:
  - On tx_done=1: pulse ack[cur_id]=1 for one cycle and clear gnt.
  - In the same cycle: ptr=(cur_id+1) mod NREQ, next state IDLE, arb_busy falls.
- Latency:
  - req rises while IDLE and transmitter is free: gnt and tx_data valid the next cycle; tx_start the cycle after.
  - tx_done at cycle m: ack at cycle m+1.
  - Earliest next gnt: cycle m+2.
  - Minimum overhead per byte: 3 cycles plus transmitter time.
- Data capture:
  - req_data is sampled only at the grant edge. The requester may change data after gnt.
  - Deasserting req after grant does not cancel the transfer; ack is still issued.
- Ignored inputs:
  - tx_done outside WAIT_DONE is ignored.
  - tx_done arriving in the same cycle as tx_start (in START) is ignored.
- Fairness: a requester holding req continuously is re-served only after every other pending requester has been served once.
- Invariants:
  - gnt is always zero or one-hot.
  - ack is never asserted in two consecutive cycles.
  - At most one tx_start per grant.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- With macro defined:
  - A 16-bit counter clears on entry to WAIT_DONE and increments each cycle in WAIT_DONE.
  - If it reaches TIMEOUT-1 without tx_done: pulse timeout_err=1 for one cycle, issue no ack, clear gnt, ptr=(cur_id+1) mod NREQ, next state IDLE.
  - tx_done in the expiry cycle takes precedence: normal ack, no error.
- Without macro:
  - No counter is instantiated and timeout_err is constant 0.
  - WAIT_DONE waits indefinitely.

Test Plan:
1. Reset mid-transfer: assert rst while in WAIT_DONE → next cycle gnt=0, arb_busy=0, tx_start=0, ptr=0; no ack for the aborted byte.
2. Single request:
   - Stimulus: req=4'b0010, req_data[15:8]=8'hA5, tx_busy=0, tx_done 20 cycles after tx_start.
   - Response: gnt=4'b0010 and tx_data=8'hA5 one cycle later; tx_start the following cycle for one cycle; ack=4'b0010 one cycle after tx_done.
3. Round-robin rotation: req=4'b1111 held, tx_done returned for each byte → grant order 0,1,2,3,0; each ack pulse matches the preceding gnt.
4. Busy hold-off: tx_busy=1 for 5 cycles after grant → tx_start stays 0 during those cycles and pulses once in the cycle tx_busy=0 is seen.
5. Request withdrawal and stray done:
   - Drop req[2] one cycle after gnt[2] → transfer completes; ack[2] still pulses.
   - tx_done pulsed in IDLE → no ack and no state change.
6. Timeout (with UART_ARB_TIMEOUT_EN, TIMEOUT=16): no tx_done → timeout_err pulses 16 cycles after WAIT_DONE entry, ack stays 0, next pending requester is granted.
